// File: rtl/pre_if_stage.sv
// pre_if_stage: owns the fetch PC and issues instruction requests on the SRAM-like req/addr_ok bus.
//   clk, reset          : clock, synchronous active-high reset
//   fs_allow_in         : IF can take a PC this cycle
//   br_bus              : {br_taken, br_target} from ID
//   ps_to_fs_valid/bus  : handoff to IF, bus = {ps_discard, ps_pc}
//   inst_sram_*         : read-only fetch request port (req/addr/addr_ok, write fields tied off)
module pre_if_stage #(
    parameter logic [31:0] RESET_PC           = 32'h1C000000,
    parameter int          WIDTH_BR_BUS       = 33,
    parameter int          WIDTH_PS_TO_FS_BUS = 33
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fs_allow_in,
    input  logic [WIDTH_BR_BUS-1:0]       br_bus,
    output logic                          ps_to_fs_valid,
    output logic [WIDTH_PS_TO_FS_BUS-1:0] ps_to_fs_bus,
    output logic                          inst_sram_req,
    output logic                          inst_sram_wr,
    output logic [1:0]                    inst_sram_size,
    output logic [3:0]                    inst_sram_wstrb,
    output logic [31:0]                   inst_sram_addr,
    output logic [31:0]                   inst_sram_wdata,
    input  logic                          inst_sram_addr_ok
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t      r_state, w_next_state;
    logic [31:0] r_pc, r_buf_target, w_next_pc, w_br_target;
    logic        r_buf_valid, r_stale, w_br_taken, w_active, w_handoff;
    assign w_br_taken  = br_bus[WIDTH_BR_BUS-1];
    assign w_br_target = br_bus[31:0];
    assign w_active    = r_state != S_IDLE;
    assign ps_to_fs_valid = (r_state == S_REQ && inst_sram_addr_ok) || r_state == S_WAIT;
    assign w_handoff      = ps_to_fs_valid && fs_allow_in;
    // A branch seen in the handoff cycle itself makes the PC being handed over wrong-path.
    assign ps_to_fs_bus    = {r_stale || (w_active && w_br_taken), r_pc};
    assign inst_sram_req   = r_state == S_REQ;
    assign inst_sram_addr  = r_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0;
    assign inst_sram_wdata = 32'b0;
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = w_br_taken ? w_br_target : r_buf_valid ? r_buf_target : r_pc + 32'd4;
        case (r_state)
            S_IDLE:  w_next_state = S_REQ;
            S_REQ:   w_next_state = (inst_sram_addr_ok && !fs_allow_in) ? S_WAIT : S_REQ;
            S_WAIT:  w_next_state = fs_allow_in ? S_REQ : S_WAIT;
            default: w_next_state = S_IDLE;
        endcase
    end
    // The request address is frozen until handoff; redirects are parked in the buffer
    // and the in-flight request is flagged stale so IF drops its data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_buf_valid  <= 1'b0;
            r_buf_target <= 32'b0;
            r_stale      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_handoff) begin
                r_pc        <= w_next_pc;
                r_buf_valid <= 1'b0;
                r_stale     <= 1'b0;
            end else if (w_active && w_br_taken) begin
                r_buf_valid  <= 1'b1;
                r_buf_target <= w_br_target;
                r_stale      <= 1'b1;
            end
        end
    end
endmodule

// File: doc/pre_if_stage.md
Name: pre_if_stage

Overview:
- Pre-IF stage that owns the fetch PC and issues instruction requests on the class-SRAM handshake bus (req/addr_ok).
- Each accepted request's PC is handed to stage1_IF, which collects data_ok/rdata. The request-to-data split lets fetch tolerate multi-cycle memory.
- Absorbs taken-branch redirects from ID at any point in the request lifecycle. Requests already accepted on the wrong path are tagged so IF discards their data.

Parameters:
RESET_PC, 32'h1C000000, first fetch address after reset
WIDTH_BR_BUS, 33, {br_taken, br_target}
WIDTH_PS_TO_FS_BUS, 33, {ps_discard, ps_pc}

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
fs_allow_in  input  1  IF can accept a PC this cycle
br_bus  input  33  {br_taken (1-cycle pulse), br_target[31:0]} from ID
ps_to_fs_valid  output  1  handoff valid to IF
ps_to_fs_bus  output  33  {ps_discard, ps_pc[31:0]}
inst_sram_req  output  1  fetch request
inst_sram_wr  output  1  tied 0
inst_sram_size  output  2  tied 2'b10 (word)
inst_sram_wstrb  output  4  tied 4'b0
inst_sram_addr  output  32  request address
inst_sram_wdata  output  32  tied 0
inst_sram_addr_ok  input  1  address accepted this cycle

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset values:
  - State = IDLE, pc_reg = RESET_PC, br_buf_valid = 0, stale = 0.
  - inst_sram_req = 0, ps_to_fs_valid = 0, ps_to_fs_bus = {1'b0, RESET_PC}.
- State machine:
  - IDLE -> REQ unconditionally in the first cycle after reset deasserts.
  - REQ: inst_sram_req = 1, inst_sram_addr = pc_reg.
    - Once req is high, addr must not change until addr_ok.
    - addr_ok & fs_allow_in: handoff this cycle, stay REQ with next PC.
    - addr_ok & !fs_allow_in: -> WAIT.
    - no addr_ok: stay REQ, same addr.
  - WAIT: inst_sram_req = 0.
    - fs_allow_in: handoff, -> REQ with next PC.
- Handoff:
  - ps_to_fs_valid = (REQ & addr_ok) | WAIT, combinationally, independent of fs_allow_in.
  - Handoff occurs when ps_to_fs_valid & fs_allow_in.
  - Zero-cycle latency from addr_ok to valid.
- Discard flag:
  - ps_discard = stale | br_taken.
  - stale is set when br_taken arrives in REQ (before or in the addr_ok cycle) or in WAIT without a same-cycle handoff. It is cleared on handoff.
  - If the branch arrives in REQ without addr_ok, the still-pending request is wrong-path and is marked discard when it is eventually handed off.
- Branch buffer:
  - br_taken in any non-IDLE cycle without handoff: br_buf_target <= br_target, br_buf_valid <= 1. A later branch overwrites the buffer.
  - The request address never changes mid-request; redirect happens only at handoff.
- Next PC at handoff, in priority order:
  1. br_taken this cycle: br_target.
  2. br_buf_valid: br_buf_target; br_buf_valid cleared.
  3. Otherwise: pc_reg + 4, 32-bit wrap (32'hFFFFFFFC -> 32'h0).
- Handoff PC: ps_pc = pc_reg at the handoff.
- Simultaneous events:
  - br_taken and handoff in the same cycle: handed PC carries discard = 1, next pc = br_target, buffer not written.
  - br_taken in IDLE is ignored.
- Reset mid-request: all state is cleared next cycle and req drops immediately. Pending bus responses belong to IF/bus cleanup.
- Throughput: one request per cycle when addr_ok and fs_allow_in are held high.

Test Plan:
- Reset released, addr_ok = 1, fs_allow_in = 1 constantly:
  - req rises 1 cycle after reset deasserts.
  - Addrs 1C000000, 1C000004, 1C000008, ... back-to-back.
  - Each ps_to_fs_valid = 1 with discard = 0.
- addr_ok held 0 for 3 cycles at addr 1C000008 -> addr stays 1C000008 and req stays 1. Handoff occurs in the addr_ok cycle.
- addr_ok = 1, fs_allow_in = 0 for 2 cycles -> WAIT: req = 0, ps_to_fs_valid = 1, pc held. Handoff when fs_allow_in = 1, next req = pc + 4.
- br_taken with target 1C000100 while in REQ at 1C00000C with addr_ok = 0 -> addr stays 1C00000C until addr_ok, that handoff has discard = 1, next req addr = 1C000100.
- br_taken with target 1C000200 in the same cycle as an addr_ok handoff of 1C000010 -> bus = {1, 1C000010}, next addr = 1C000200, buffer not written.
- Reset asserted while in WAIT with br_buf_valid = 1 -> next cycle req = 0, valid = 0. Fetch restarts at 1C000000 with the buffer cleared.
